// File: rtl/mem_bank_sync.sv
// mem_bank_sync: DEPTH x WIDTH register bank written by a synchronised, edge-detected store button.
//   clk      : system clock
//   rst      : asynchronous active-high reset
//   store    : raw write button, asynchronous to clk; one write per rising edge
//   clr      : synchronous level clear of all words, written mask and rd_data
//   wr_data  : write data, sampled at the commit edge
//   wr_addr  : write address, sampled at the commit edge
//   rd_addr  : read address
//   rd_data  : registered read data, with write-through bypass
//   mem_flat : all words, word i at [i*WIDTH +: WIDTH]
//   written  : bit i set once word i is written since reset/clear
//   wr_pulse : high for the cycle in which a write commits
//   wr_count : committed write count, saturating (only with MEM_BANK_SYNC_WRCOUNT_EN)
module mem_bank_sync #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          store,
    input  logic                          clr,
    input  logic [WIDTH-1:0]              wr_data,
    input  logic [ADDR_W-1:0]             wr_addr,
    input  logic [ADDR_W-1:0]             rd_addr,
    output logic [WIDTH-1:0]              rd_data,
    output logic [WIDTH*(2**ADDR_W)-1:0]  mem_flat,
    output logic [(2**ADDR_W)-1:0]        written,
    output logic                          wr_pulse
`ifdef MEM_BANK_SYNC_WRCOUNT_EN
    ,
    output logic [15:0]                   wr_count
`endif
);
    localparam int DEPTH = 2**ADDR_W;

    logic             s1_q, s2_q, s3_q;
    logic             wr_en;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0] written_q, written_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;

    // Reading from the next-state array gives clear and write-through bypass for free.
    always_comb begin
        wr_pulse  = s2_q & ~s3_q;
        wr_en     = wr_pulse & ~clr;
        mem_d     = mem_q;
        written_d = written_q;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
            written_d = '0;
        end else if (wr_en) begin
            mem_d[wr_addr]     = wr_data;
            written_d[wr_addr] = 1'b1;
        end
        rd_data_d = mem_d[rd_addr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {s1_q, s2_q, s3_q} <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            written_q <= '0;
            rd_data_q <= '0;
        end else begin
            {s1_q, s2_q, s3_q} <= {store, s1_q, s2_q};
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            written_q <= written_d;
            rd_data_q <= rd_data_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) mem_flat[i*WIDTH +: WIDTH] = mem_q[i];
    end

    assign rd_data = rd_data_q;
    assign written = written_q;

`ifdef MEM_BANK_SYNC_WRCOUNT_EN
    logic [15:0] wr_count_q, wr_count_d;

    always_comb begin
        wr_count_d = clr ? 16'd0 : (wr_en && wr_count_q != 16'hFFFF) ? wr_count_q + 16'd1 : wr_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_count_q <= '0;
        else     wr_count_q <= wr_count_d;
    end

    assign wr_count = wr_count_q;
`endif
endmodule

// File: tb/tb_mem_bank_sync.sv
// tb_mem_bank_sync: directed self-checking bench for mem_bank_sync.
module tb_mem_bank_sync;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        store = 1'b0;
    logic        clr = 1'b0;
    logic [7:0]  wr_data = '0;
    logic [1:0]  wr_addr = '0;
    logic [1:0]  rd_addr = '0;
    logic [7:0]  rd_data;
    logic [31:0] mem_flat;
    logic [3:0]  written;
    logic        wr_pulse;
`ifdef MEM_BANK_SYNC_WRCOUNT_EN
    logic [15:0] wr_count;
`endif
    int errors = 0;
    int checks = 0;

    mem_bank_sync dut (
        .clk(clk), .rst(rst), .store(store), .clr(clr),
        .wr_data(wr_data), .wr_addr(wr_addr), .rd_addr(rd_addr),
        .rd_data(rd_data), .mem_flat(mem_flat), .written(written),
        .wr_pulse(wr_pulse)
`ifdef MEM_BANK_SYNC_WRCOUNT_EN
        , .wr_count(wr_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [1:0] a, input logic [7:0] d);
        wr_addr = a;
        wr_data = d;
        store = 1'b1;
        tick(); tick(); tick();
        store = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        checks++; if (mem_flat !== 32'h0) begin errors++; $display("FAIL reset_mem_flat got %h want %h", mem_flat, 32'h0); end
        checks++; if (written !== 4'h0) begin errors++; $display("FAIL reset_written got %b want %b", written, 4'h0); end
        checks++; if (rd_data !== 8'h0) begin errors++; $display("FAIL reset_rd_data got %h want %h", rd_data, 8'h0); end
        checks++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL reset_wr_pulse got %b want %b", wr_pulse, 1'b0); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single_write();
        wr_addr = 2'd2;
        wr_data = 8'hA5;
        store = 1'b1;
        tick();
        checks++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL single_pulse_k got %b want %b", wr_pulse, 1'b0); end
        tick();
        checks++; if (wr_pulse !== 1'b1) begin errors++; $display("FAIL single_pulse_k1 got %b want %b", wr_pulse, 1'b1); end
        store = 1'b0;
        tick();
        checks++; if (wr_pulse !== 1'b0) begin errors++; $display("FAIL single_pulse_k2 got %b want %b", wr_pulse, 1'b0); end
        checks++; if (mem_flat !== 32'h00A5_0000) begin errors++; $display("FAIL single_mem_flat got %h want %h", mem_flat, 32'h00A5_0000); end
        checks++; if (written !== 4'b0100) begin errors++; $display("FAIL single_written got %b want %b", written, 4'b0100); end
        tick(); tick();
    endtask

    task automatic test_hold();
        int pulses = 0;
        wr_addr = 2'd1;
        wr_data = 8'h3C;
        store = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (wr_pulse) pulses++;
            if (i == 5) wr_data = 8'hFF;
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL hold_pulses got %0d want %0d", pulses, 1); end
        checks++; if (mem_flat !== 32'h00A5_3C00) begin errors++; $display("FAIL hold_mem_flat got %h want %h", mem_flat, 32'h00A5_3C00); end
        store = 1'b0;
        tick(); tick(); tick();
    endtask

    task automatic test_bypass();
        rd_addr = 2'd3;
        wr_addr = 2'd3;
        wr_data = 8'h5A;
        store = 1'b1;
        tick(); tick();
        store = 1'b0;
        tick();
        checks++; if (rd_data !== 8'h5A) begin errors++; $display("FAIL bypass_rd_data got %h want %h", rd_data, 8'h5A); end
        rd_addr = 2'd0;
        tick();
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL read_addr0 got %h want %h", rd_data, 8'h00); end
        checks++; if (written !== 4'b1110) begin errors++; $display("FAIL bypass_written got %b want %b", written, 4'b1110); end
        tick(); tick();
    endtask

    task automatic test_clr();
        press(2'd0, 8'h11);
        press(2'd1, 8'h22);
        press(2'd2, 8'h33);
        press(2'd3, 8'h44);
        checks++; if (mem_flat !== 32'h4433_2211) begin errors++; $display("FAIL fill_mem_flat got %h want %h", mem_flat, 32'h4433_2211); end
        checks++; if (written !== 4'hF) begin errors++; $display("FAIL fill_written got %b want %b", written, 4'hF); end
        rd_addr = 2'd2;
        wr_addr = 2'd0;
        wr_data = 8'h99;
        store = 1'b1;
        tick(); tick();
        checks++; if (wr_pulse !== 1'b1) begin errors++; $display("FAIL clr_pulse got %b want %b", wr_pulse, 1'b1); end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        store = 1'b0;
        checks++; if (mem_flat !== 32'h0) begin errors++; $display("FAIL clr_mem_flat got %h want %h", mem_flat, 32'h0); end
        checks++; if (written !== 4'h0) begin errors++; $display("FAIL clr_written got %b want %b", written, 4'h0); end
        checks++; if (rd_data !== 8'h0) begin errors++; $display("FAIL clr_rd_data got %h want %h", rd_data, 8'h0); end
`ifdef MEM_BANK_SYNC_WRCOUNT_EN
        checks++; if (wr_count !== 16'd0) begin errors++; $display("FAIL clr_wr_count got %0d want %0d", wr_count, 0); end
`endif
        tick(); tick(); tick();
        checks++; if (mem_flat !== 32'h0) begin errors++; $display("FAIL clr_after_mem_flat got %h want %h", mem_flat, 32'h0); end
    endtask

    task automatic test_rst_mid_press();
        int pulses = 0;
        press(2'd1, 8'h77);
        rd_addr = 2'd1;
        tick();
        checks++; if (rd_data !== 8'h77) begin errors++; $display("FAIL pre_rst_rd_data got %h want %h", rd_data, 8'h77); end
        wr_addr = 2'd2;
        wr_data = 8'hEE;
        store = 1'b1;
        tick();
        #2 rst = 1'b1;
        #1;
        checks++; if (mem_flat !== 32'h0) begin errors++; $display("FAIL async_rst_mem_flat got %h want %h", mem_flat, 32'h0); end
        checks++; if (rd_data !== 8'h0) begin errors++; $display("FAIL async_rst_rd_data got %h want %h", rd_data, 8'h0); end
        checks++; if (written !== 4'h0) begin errors++; $display("FAIL async_rst_written got %b want %b", written, 4'h0); end
        store = 1'b0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (wr_pulse) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL rst_mid_pulses got %0d want %0d", pulses, 0); end
        checks++; if (mem_flat !== 32'h0) begin errors++; $display("FAIL rst_mid_mem_flat got %h want %h", mem_flat, 32'h0); end
    endtask

`ifdef MEM_BANK_SYNC_WRCOUNT_EN
    task automatic test_wr_count();
        for (int i = 0; i < 5; i++) press(2'(i), 8'(i + 1));
        checks++; if (wr_count !== 16'd5) begin errors++; $display("FAIL wr_count_5 got %0d want %0d", wr_count, 5); end
        force dut.wr_count_q = 16'hFFFF;
        tick();
        release dut.wr_count_q;
        press(2'd0, 8'h01);
        checks++; if (wr_count !== 16'hFFFF) begin errors++; $display("FAIL wr_count_sat got %h want %h", wr_count, 16'hFFFF); end
    endtask
`endif

    initial begin
        test_reset();
        test_single_write();
        test_hold();
        test_bypass();
        test_clr();
        test_rst_mid_press();
`ifdef MEM_BANK_SYNC_WRCOUNT_EN
        test_wr_count();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
